// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU and its issue controller.
package alu_pkg;

    localparam int unsigned DW = 16;

    // Opcodes shared with the ALU; the issue controller forwards them untouched
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } issue_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; head entry is readable combinationally.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 36
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;

    // Storage is not reset; only the pointers and count define validity
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CNTW'(push) - CNTW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// In-order, single-in-flight issue stage for the ALU with a buffered command port.
// Optional statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ALU_LATENCY = 2,
    parameter int unsigned DW          = alu_pkg::DW
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_opcode,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    output logic          alu_enable,
    output logic [3:0]    alu_opcode,
    output logic [DW-1:0] alu_data_a,
    output logic [DW-1:0] alu_data_b,
    input  logic [DW-1:0] alu_results,
    input  logic          alu_cf,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_result,
`ifdef ALU_ISSUE_STATS_EN
    output logic [15:0]   stat_issued,
    output logic [15:0]   stat_carry,
`endif
    output logic          rsp_cf
);

    import alu_pkg::*;

    localparam int unsigned CW  = 4 + 2 * DW;
    localparam int unsigned WCW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    issue_state_e   state_q;
    issue_state_e   state_d;
    logic [WCW-1:0] wcnt_q;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_rdata;
    logic [CW-1:0]  issue_word_c;
    logic           cmd_avail_c;
    logic           capture_c;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && !fifo_full;
    assign fifo_pop  = (state_q == ISSUE);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CW)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({cmd_opcode, cmd_a, cmd_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A command pushed during the RESP handshake into an empty FIFO is not yet in storage
    assign cmd_avail_c  = !fifo_empty || fifo_push;
    assign issue_word_c = fifo_empty ? {cmd_opcode, cmd_a, cmd_b} : fifo_rdata;
    assign capture_c    = (state_q == WAIT) && (state_d == RESP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == WCW'(ALU_LATENCY - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = cmd_avail_c ? ISSUE : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            alu_enable <= 1'b0;
            alu_opcode <= '0;
            alu_data_a <= '0;
            alu_data_b <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_cf     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_enable <= (state_d == ISSUE);
            wcnt_q     <= (state_q == WAIT) ? wcnt_q + WCW'(1) : '0;
            // Operands stay put until the next issue so the ALU sees them through WAIT
            if (state_d == ISSUE) begin
                {alu_opcode, alu_data_a, alu_data_b} <= issue_word_c;
            end
            if (capture_c) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_results;
                rsp_cf     <= alu_cf;
            end else if ((state_q == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating event counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_issued <= '0;
            stat_carry  <= '0;
        end else begin
            if ((state_q == ISSUE) && (stat_issued != 16'hFFFF)) begin
                stat_issued <= stat_issued + 16'd1;
            end
            if (capture_c && alu_cf && (stat_carry != 16'hFFFF)) begin
                stat_carry <= stat_carry + 16'd1;
            end
        end
    end
`endif

endmodule
